fpga_mem_responder: RTL

FPGA_MEM_RESPONDER -- requirements
Module: fpga_mem_responder

---
 rtl/fpga_mem_pkg.sv | 25 ++
 rtl/fpga_mem_ram.sv | 28 ++
 rtl/fpga_mem_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fpga_mem_pkg.sv
// Shared constants, FSM state type and address-phase decode for the
// fpga_mem_responder slice.
package fpga_mem_pkg;

    localparam int unsigned BEATS      = 8;   // 32-bit words per 32-byte line
    localparam int unsigned BEAT_W     = 3;   // beat counter width
    localparam int unsigned LINE_OFF_W = 5;   // byte-offset bits inside a line
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR_ACK = 3'd1,
        S_WR_BEAT  = 3'd2,
        S_WR_DONE  = 3'd3,
        S_RD_BEAT  = 3'd4
    } state_e;

    // An address phase starts a transaction only with exactly one enable set.
    function automatic logic addr_phase_valid(input logic address_on,
                                              input logic read_en,
                                              input logic write_en);
        return address_on && (read_en ^ write_en);
    endfunction

endpackage

// File: rtl/fpga_mem_ram.sv
// Single-port synchronous RAM, 32-bit words, 1-cycle read latency.
// Ports: clk; we (write enable); addr (word index); wdata; rdata (registered
// read of addr, valid the cycle after addr is presented).
module fpga_mem_ram
    import fpga_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is intentionally not reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/fpga_mem_responder.sv
// Memory-side responder for a multiplexed address/data line-transfer bus.
// Each transaction: address phase, 8 data beats, plus a completion resp for
// writes. Every resp pulse is followed by GAP cycles in which nothing is
// evaluated.
// Ports: clk, rst (sync, active-high); address_data_bus_c_to_m (address or
// write word); address_on/data_on_c_to_m (phase qualifiers);
// read_en/write_en_c_to_m (transaction type); address_data_bus_m_to_c (read
// word, zero unless resp); resp_m_to_c (one-cycle acknowledge).
module fpga_mem_responder
    import fpga_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned GAP    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] address_data_bus_c_to_m,
    input  logic              address_on_c_to_m,
    input  logic              data_on_c_to_m,
    input  logic              read_en_c_to_m,
    input  logic              write_en_c_to_m,
    output logic [DATA_W-1:0] address_data_bus_m_to_c,
    output logic              resp_m_to_c
);

    localparam int unsigned BASE_W = ADDR_W - BEAT_W;
    localparam int unsigned WAIT_W = $clog2(GAP + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e              state;
    logic                is_write;
    logic [BASE_W-1:0]   base;
    logic [BEAT_W-1:0]   beat;
    logic                waiting;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                rd_pending;

    logic                active_en_c;
    logic                ram_we_c;
    logic [ADDR_W-1:0]   ram_addr_c;
    logic [DATA_W-1:0]   ram_rdata;

    assign active_en_c = is_write ? write_en_c_to_m : read_en_c_to_m;
    assign ram_addr_c  = {base, beat};

    // A write beat commits on the same edge that registers its resp.
    assign ram_we_c = !rst && !waiting && (state == S_WR_BEAT)
                      && write_en_c_to_m && data_on_c_to_m;

    fpga_mem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (address_data_bus_c_to_m),
        .rdata (ram_rdata)
    );

    // Transaction FSM; the resp cycle itself is the first cycle of the wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= S_IDLE;
            is_write                <= 1'b0;
            base                    <= '0;
            beat                    <= '0;
            waiting                 <= 1'b0;
            wait_cnt                <= '0;
            rd_pending              <= 1'b0;
            resp_m_to_c             <= 1'b0;
            address_data_bus_m_to_c <= '0;
        end else begin
            resp_m_to_c             <= 1'b0;
            address_data_bus_m_to_c <= '0;

            if (waiting) begin
                if (wait_cnt == '0) begin
                    waiting <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (addr_phase_valid(address_on_c_to_m, read_en_c_to_m,
                                             write_en_c_to_m)) begin
                            base     <= address_data_bus_c_to_m[ADDR_W+1:LINE_OFF_W];
                            is_write <= write_en_c_to_m;
                            beat     <= '0;
                            state    <= S_ADDR_ACK;
                        end
                    end

                    S_ADDR_ACK: begin
                        if (!active_en_c) begin
                            state <= S_IDLE;
                        end else begin
                            resp_m_to_c <= 1'b1;
                            waiting     <= 1'b1;
                            wait_cnt    <= WAIT_W'(GAP);
                            state       <= is_write ? S_WR_BEAT : S_RD_BEAT;
                        end
                    end

                    S_WR_BEAT: begin
                        if (!active_en_c) begin
                            state <= S_IDLE;
                            beat  <= '0;
                        end else if (data_on_c_to_m) begin
                            resp_m_to_c <= 1'b1;
                            waiting     <= 1'b1;
                            wait_cnt    <= WAIT_W'(GAP);
                            if (beat == LAST_BEAT) begin
                                state <= S_WR_DONE;
                            end else begin
                                beat <= beat + BEAT_W'(1);
                            end
                        end
                    end

                    // Completion resp is sent regardless of the enables.
                    S_WR_DONE: begin
                        resp_m_to_c <= 1'b1;
                        waiting     <= 1'b1;
                        wait_cnt    <= WAIT_W'(GAP);
                        beat        <= '0;
                        state       <= S_IDLE;
                    end

                    // First eligible cycle launches the RAM read; the next
                    // cycle registers the returned word with resp.
                    S_RD_BEAT: begin
                        if (!active_en_c) begin
                            state      <= S_IDLE;
                            beat       <= '0;
                            rd_pending <= 1'b0;
                        end else if (rd_pending) begin
                            rd_pending              <= 1'b0;
                            resp_m_to_c             <= 1'b1;
                            address_data_bus_m_to_c <= ram_rdata;
                            waiting                 <= 1'b1;
                            wait_cnt                <= WAIT_W'(GAP);
                            if (beat == LAST_BEAT) begin
                                beat  <= '0;
                                state <= S_IDLE;
                            end else begin
                                beat <= beat + BEAT_W'(1);
                            end
                        end else if (data_on_c_to_m) begin
                            rd_pending <= 1'b1;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
